// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-order queue of predicted branches resolved against M-stage outcomes
// Emits registered mispredict/redirect/flush and a predictor training record per resolve.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [PC_W-1:0]          push_pc,
  input  logic                     push_ptaken,
  input  logic [PC_W-1:0]          push_ptarget,
  output logic                     push_ready,
  input  logic                     res_valid,
  input  logic [PC_W-1:0]          res_pc,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  output logic                     mispredict,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     flush,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic                     upd_mis,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     order_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            order_err_q, order_err_d;
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [PC_W-1:0] pc_d [DEPTH];
  logic [PC_W-1:0] ptarget_q [DEPTH];
  logic [PC_W-1:0] ptarget_d [DEPTH];
  logic [DEPTH-1:0] ptaken_q, ptaken_d;

  logic            mis_q, mis_d;
  logic [PC_W-1:0] redirect_q, redirect_d;
  logic            upd_valid_q, upd_valid_d;
  logic [PC_W-1:0] upd_pc_q, upd_pc_d;
  logic            upd_taken_q, upd_taken_d;
  logic            upd_mis_q, upd_mis_d;

  logic            in_run, do_res, do_push, mis;
  logic [PC_W-1:0] head_pc, head_ptarget;
  logic            head_ptaken;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Next state: a mispredict costs exactly one recovery cycle
  always_comb begin
    state_d = RUN;
    if (state_q == RUN && mis) state_d = RECOVER;
  end

  // FSM outputs
  always_comb begin
    in_run     = (state_q == RUN);
    push_ready = in_run & ((count_q < CW'(DEPTH)) | res_valid);
  end

  always_comb begin
    head_pc      = pc_q[rd_ptr_q];
    head_ptarget = ptarget_q[rd_ptr_q];
    head_ptaken  = ptaken_q[rd_ptr_q];
    do_res       = res_valid & in_run & (count_q != '0);
    do_push      = push_valid & push_ready;
    mis          = do_res & ((res_taken != head_ptaken) |
                             (res_taken & (res_target != head_ptarget)));

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_d       = pc_q;
    ptarget_d  = ptarget_q;
    ptaken_d   = ptaken_q;
    if (mis) begin
      // Flush discards everything, including a push arriving this cycle
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        pc_d[wr_ptr_q]       = push_pc;
        ptarget_d[wr_ptr_q]  = push_ptarget;
        ptaken_d[wr_ptr_q]   = push_ptaken;
        wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (do_res) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_res);
    end

    order_err_d = order_err_q |
                  (res_valid & in_run & ((count_q == '0) | (res_pc != head_pc)));

    mis_d       = mis;
    redirect_d  = '0;
    if (mis) redirect_d = res_taken ? res_target : head_pc + PC_W'(8);
    upd_valid_d = do_res;
    upd_pc_d    = do_res ? head_pc : '0;
    upd_taken_d = do_res & res_taken;
    upd_mis_d   = mis;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      order_err_q <= 1'b0;
      mis_q       <= 1'b0;
      redirect_q  <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      upd_mis_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      order_err_q <= order_err_d;
      mis_q       <= mis_d;
      redirect_q  <= redirect_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      upd_mis_q   <= upd_mis_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    pc_q      <= pc_d;
    ptarget_q <= ptarget_d;
    ptaken_q  <= ptaken_d;
  end

  always_comb begin
    mispredict  = mis_q;
    flush       = mis_q;
    redirect_pc = redirect_q;
    upd_valid   = upd_valid_q;
    upd_pc      = upd_pc_q;
    upd_taken   = upd_taken_q;
    upd_mis     = upd_mis_q;
    count       = count_q;
    order_err   = order_err_q;
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed and random checks of branch_resolver against a queue model
module tb_branch_resolver;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            push_valid, push_ptaken, push_ready;
  logic [PC_W-1:0] push_pc, push_ptarget;
  logic            res_valid, res_taken;
  logic [PC_W-1:0] res_pc, res_target;
  logic            mispredict, flush, upd_valid, upd_taken, upd_mis, order_err;
  logic [PC_W-1:0] redirect_pc, upd_pc;
  logic [2:0]      count;

  branch_resolver #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pc(push_pc), .push_ptaken(push_ptaken),
    .push_ptarget(push_ptarget), .push_ready(push_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mis(upd_mis),
    .count(count), .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
  } ent_t;

  ent_t q[$];
  bit   m_recover;
  bit   m_oerr;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    push_valid = 0; push_pc = '0; push_ptaken = 0; push_ptarget = '0;
    res_valid = 0; res_pc = '0; res_taken = 0; res_target = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    @(posedge clk); #1;
    q.delete(); m_recover = 0; m_oerr = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_mispredict", 32'(mispredict), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_order_err", 32'(order_err), 0);
    rst = 1;
    idle_inputs();
    #1;
    chk("rst_push_ready", 32'(push_ready), 1);
  endtask

  task automatic step(input bit pv, input logic [31:0] ppc, input bit pt, input logic [31:0] ptg,
                      input bit rv, input logic [31:0] rpc, input bit rt, input logic [31:0] rtg);
    bit          exp_ready, res_ok, e_mis;
    logic [31:0] e_redir, e_upc;
    ent_t        h;
    push_valid = pv; push_pc = ppc; push_ptaken = pt; push_ptarget = ptg;
    res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtg;
    #1;
    exp_ready = !m_recover && (q.size() < DEPTH || rv);
    chk("push_ready", 32'(push_ready), 32'(exp_ready));
    res_ok = rv && !m_recover && q.size() != 0;
    if (rv && !m_recover && (q.size() == 0 || rpc != q[0].pc)) m_oerr = 1;
    e_mis = 0; e_redir = '0; e_upc = '0;
    if (res_ok) begin
      h      = q.pop_front();
      e_mis  = (rt != h.pt) || (rt && rtg != h.ptg);
      e_redir = rt ? rtg : h.pc + 32'd8;
      e_upc  = h.pc;
    end
    if (e_mis) begin
      q.delete();
      m_recover = 1;
    end else begin
      if (pv && exp_ready) q.push_back('{pc: ppc, pt: pt, ptg: ptg});
      m_recover = 0;
    end
    @(posedge clk); #1;
    chk("mispredict", 32'(mispredict), 32'(e_mis));
    chk("flush", 32'(flush), 32'(e_mis));
    chk("upd_valid", 32'(upd_valid), 32'(res_ok));
    if (res_ok) begin
      chk("upd_pc", upd_pc, e_upc);
      chk("upd_taken", 32'(upd_taken), 32'(rt));
      chk("upd_mis", 32'(upd_mis), 32'(e_mis));
    end
    if (e_mis) chk("redirect_pc", redirect_pc, e_redir);
    chk("count", 32'(count), 32'(q.size()));
    chk("order_err", 32'(order_err), 32'(m_oerr));
    idle_inputs();
  endtask

  initial begin
    logic [31:0] r_pc, r_tg;
    idle_inputs();
    do_reset();

    // 1: correctly predicted taken branch
    step(1, 32'h100, 1, 32'h200, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h100, 1, 32'h200);

    // 2: predicted not-taken, actually taken; one recovery cycle follows
    step(1, 32'h100, 0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h100, 1, 32'h400);
    step(1, 32'h180, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // 3: predicted taken, actually not-taken -> fall through past delay slot
    step(1, 32'h100, 1, 32'h200, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h100, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // PC wrap-around on the fall-through path
    step(1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // 4: fill, drop fifth, push+resolve when full, drain in order
    for (int i = 1; i <= 4; i++) step(1, 32'(i * 16), 0, 0, 0, 0, 0, 0);
    step(1, 32'h999, 0, 0, 0, 0, 0, 0);
    step(1, 32'h50, 0, 0, 1, 32'h10, 0, 0);
    for (int i = 2; i <= 5; i++) step(0, 0, 0, 0, 1, 32'(i * 16), 0, 0);

    // 5: head mispredicts while a push is offered
    for (int i = 1; i <= 3; i++) step(1, 32'(32'h1000 + i * 4), 1, 32'h2000, 0, 0, 0, 0);
    step(1, 32'h3000, 0, 0, 1, 32'h1004, 1, 32'h2400);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h3000, 0, 0);

    // 6: resolve on empty queue, then reset mid-fill with a resolve pending
    step(0, 0, 0, 0, 1, 32'h500, 1, 32'h600);
    step(1, 32'h700, 0, 0, 0, 0, 0, 0);
    step(1, 32'h704, 1, 32'h800, 0, 0, 0, 0);
    push_valid = 1; push_pc = 32'h708;
    res_valid = 1; res_pc = 32'h700; res_taken = 1; res_target = 32'h900;
    do_reset();

    // Random traffic with mostly in-order resolves
    for (int n = 0; n < 400; n++) begin
      r_pc = (q.size() != 0 && $urandom_range(0, 19) != 0) ? q[0].pc : 32'($urandom_range(0, 15) * 4);
      r_tg = ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300;
      step($urandom_range(0, 1) != 0, 32'($urandom_range(0, 15) * 4), $urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300,
           $urandom_range(0, 2) == 0, r_pc, $urandom_range(0, 3) != 0, r_tg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
